// File: rtl/jk_excitation_seq.sv
// Drives J/K into an external JK flip-flop so that its Q follows a target pattern,
// then checks the returned Q two cycles later and keeps a saturating mismatch count.
module jk_excitation_seq #(
   parameter int DEPTH     = 8,
   parameter int IDX_W     = 3,
   parameter int CNT_W     = 4,
   parameter int DC_POLICY = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DEPTH-1:0] pattern,
   input  logic             q_fb,
   output logic             ff_reset,
   output logic             j,
   output logic             k,
   output logic             busy,
   output logic             mismatch,
   output logic [CNT_W-1:0] err_cnt,
   output logic [IDX_W-1:0] first_err_idx,
   output logic             done,
   output logic             pass
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [DEPTH-1:0]   pat_q, pat_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               model_q, model_d;
   logic               drain_q, drain_d;
   logic               j_q, j_d, k_q, k_d;
   logic               ff_reset_q, ff_reset_d;
   logic               busy_q, busy_d;
   logic               mismatch_q, mismatch_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [IDX_W-1:0]   first_err_idx_q, first_err_idx_d;
   logic               s1_vld_q, s1_vld_d, s1_exp_q, s1_exp_d;
   logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
   logic               s2_vld_q, s2_vld_d, s2_exp_q, s2_exp_d;
   logic [IDX_W-1:0]   s2_idx_q, s2_idx_d;
   logic               step_bit;
   logic [1:0]         step_jk;

   // Excitation table; returns {J, K} for the transition cur -> nxt.
   function automatic logic [1:0] exc(input logic cur, input logic nxt);
      logic [1:0] jk;
      if (DC_POLICY == 0) jk = {~cur & nxt, cur & ~nxt};
      else                jk = {cur ^ nxt, cur ^ nxt};
      return jk;
   endfunction

   always_comb begin
      state_d         = state_q;
      pat_d           = pat_q;
      idx_d           = idx_q;
      model_d         = model_q;
      drain_d         = drain_q;
      j_d             = 1'b0;
      k_d             = 1'b0;
      ff_reset_d      = ff_reset_q;
      busy_d          = busy_q;
      mismatch_d      = 1'b0;
      done_d          = 1'b0;
      pass_d          = 1'b0;
      err_cnt_d       = err_cnt_q;
      first_err_idx_d = first_err_idx_q;
      s1_vld_d        = 1'b0;
      s1_exp_d        = s1_exp_q;
      s1_idx_d        = s1_idx_q;
      s2_vld_d        = s1_vld_q;
      s2_exp_d        = s1_exp_q;
      s2_idx_d        = s1_idx_q;
      step_bit        = pat_q[idx_q];
      step_jk         = exc(model_q, step_bit);

      // Stage 2 holds the step whose flip-flop update is visible on q_fb this cycle.
      if (s2_vld_q && (q_fb != s2_exp_q)) begin
         mismatch_d = 1'b1;
         if (err_cnt_q == '0) first_err_idx_d = s2_idx_q;
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               pat_d           = pattern;
               err_cnt_d       = '0;
               first_err_idx_d = '0;
               idx_d           = '0;
               model_d         = 1'b0;
               ff_reset_d      = 1'b1;
               busy_d          = 1'b1;
               state_d         = S_CLR;
            end
         end
         // The CLR exit edge already launches step 0, so RUN covers steps 1..DEPTH-1.
         S_CLR, S_RUN: begin
            ff_reset_d = 1'b0;
            j_d        = step_jk[1];
            k_d        = step_jk[0];
            model_d    = step_bit;
            s1_vld_d   = 1'b1;
            s1_exp_d   = step_bit;
            s1_idx_d   = idx_q;
            idx_d      = idx_q + 1'b1;
            if (idx_q == IDX_W'(DEPTH - 1)) begin
               drain_d = 1'b0;
               state_d = S_DRAIN;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_cnt_d == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         pat_q           <= '0;
         idx_q           <= '0;
         model_q         <= 1'b0;
         drain_q         <= 1'b0;
         j_q             <= 1'b0;
         k_q             <= 1'b0;
         ff_reset_q      <= 1'b0;
         busy_q          <= 1'b0;
         mismatch_q      <= 1'b0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
         err_cnt_q       <= '0;
         first_err_idx_q <= '0;
         s1_vld_q        <= 1'b0;
         s1_exp_q        <= 1'b0;
         s1_idx_q        <= '0;
         s2_vld_q        <= 1'b0;
         s2_exp_q        <= 1'b0;
         s2_idx_q        <= '0;
      end else begin
         state_q         <= state_d;
         pat_q           <= pat_d;
         idx_q           <= idx_d;
         model_q         <= model_d;
         drain_q         <= drain_d;
         j_q             <= j_d;
         k_q             <= k_d;
         ff_reset_q      <= ff_reset_d;
         busy_q          <= busy_d;
         mismatch_q      <= mismatch_d;
         done_q          <= done_d;
         pass_q          <= pass_d;
         err_cnt_q       <= err_cnt_d;
         first_err_idx_q <= first_err_idx_d;
         s1_vld_q        <= s1_vld_d;
         s1_exp_q        <= s1_exp_d;
         s1_idx_q        <= s1_idx_d;
         s2_vld_q        <= s2_vld_d;
         s2_exp_q        <= s2_exp_d;
         s2_idx_q        <= s2_idx_d;
      end
   end

   assign ff_reset      = ff_reset_q;
   assign j             = j_q;
   assign k             = k_q;
   assign busy          = busy_q;
   assign mismatch      = mismatch_q;
   assign err_cnt       = err_cnt_q;
   assign first_err_idx = first_err_idx_q;
   assign done          = done_q;
   assign pass          = pass_q;

endmodule

// File: tb/tb_jk_excitation_seq.sv
// Bench for jk_excitation_seq: three instances (set/reset form, toggle form, 2-bit counter)
// share stimulus; each drives its own modelled JK flip-flop with a selectable fault.
module tb_jk_excitation_seq;

   localparam int DEPTH = 8;
   localparam int NI    = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start;
   logic [7:0]  pattern;
   int          fault_mode;   // 0 correct JKFF, 1 q_fb stuck at 0, 2 set-only JKFF
   logic        chk_en = 1'b0;

   logic [NI-1:0] ff_reset_w, j_w, k_w, busy_w, mismatch_w, done_w, pass_w, q_fb_w;
   logic [NI-1:0] ffq = '0;
   logic [3:0]    err0, err1;
   logic [1:0]    err2;
   logic [2:0]    first0, first1, first2;
   logic [3:0]    err_a [NI];
   logic [2:0]    first_a [NI];

   always_comb begin
      err_a[0]   = err0;
      err_a[1]   = err1;
      err_a[2]   = {2'b00, err2};
      first_a[0] = first0;
      first_a[1] = first1;
      first_a[2] = first2;
   end

   jk_excitation_seq #(.DEPTH(8), .IDX_W(3), .CNT_W(4), .DC_POLICY(0)) u0 (
      .clk(clk), .reset(reset), .start(start), .pattern(pattern), .q_fb(q_fb_w[0]),
      .ff_reset(ff_reset_w[0]), .j(j_w[0]), .k(k_w[0]), .busy(busy_w[0]),
      .mismatch(mismatch_w[0]), .err_cnt(err0), .first_err_idx(first0),
      .done(done_w[0]), .pass(pass_w[0]));

   jk_excitation_seq #(.DEPTH(8), .IDX_W(3), .CNT_W(4), .DC_POLICY(1)) u1 (
      .clk(clk), .reset(reset), .start(start), .pattern(pattern), .q_fb(q_fb_w[1]),
      .ff_reset(ff_reset_w[1]), .j(j_w[1]), .k(k_w[1]), .busy(busy_w[1]),
      .mismatch(mismatch_w[1]), .err_cnt(err1), .first_err_idx(first1),
      .done(done_w[1]), .pass(pass_w[1]));

   jk_excitation_seq #(.DEPTH(8), .IDX_W(3), .CNT_W(2), .DC_POLICY(0)) u2 (
      .clk(clk), .reset(reset), .start(start), .pattern(pattern), .q_fb(q_fb_w[2]),
      .ff_reset(ff_reset_w[2]), .j(j_w[2]), .k(k_w[2]), .busy(busy_w[2]),
      .mismatch(mismatch_w[2]), .err_cnt(err2), .first_err_idx(first2),
      .done(done_w[2]), .pass(pass_w[2]));

   // External flip-flops (the device under stimulus)
   always @(posedge clk) begin
      for (int n = 0; n < NI; n++) begin
         if (ff_reset_w[n]) ffq[n] <= 1'b0;
         else if (fault_mode == 2) begin
            if (j_w[n]) ffq[n] <= 1'b1;
         end else begin
            case ({j_w[n], k_w[n]})
               2'b01:   ffq[n] <= 1'b0;
               2'b10:   ffq[n] <= 1'b1;
               2'b11:   ffq[n] <= ~ffq[n];
               default: ffq[n] <= ffq[n];
            endcase
         end
      end
   end
   assign q_fb_w = (fault_mode == 1) ? '0 : ffq;

   // ---------------- reference model ----------------
   int pol [NI] = '{0, 1, 0};
   int sat [NI] = '{15, 15, 3};
   int edge_n = 0;
   int s_edge = 0;
   bit active = 1'b0;
   bit [1:0] m_jk [NI][DEPTH];
   bit       m_mm [NI][DEPTH];

   task automatic build_model();
      bit prev, dev, t, jj, kk;
      for (int n = 0; n < NI; n++) begin
         prev = 1'b0;
         dev  = 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            t = pattern[i];
            if (pol[n] == 0) begin
               jj = t & ~prev;
               kk = prev & ~t;
            end else begin
               jj = t ^ prev;
               kk = jj;
            end
            m_jk[n][i] = {jj, kk};
            if (fault_mode == 0) dev = (jj & kk) ? ~dev : (jj ? 1'b1 : (kk ? 1'b0 : dev));
            else if (fault_mode == 1) dev = 1'b0;
            else if (jj) dev = 1'b1;
            m_mm[n][i] = (dev != t);
            prev = t;
         end
      end
   endtask

   // Saturating count and first failing step over steps 0..last
   function automatic void model_err(input int n, input int last, output int cnt, output int first);
      cnt = 0;
      first = 0;
      for (int i = 0; i <= last && i < DEPTH; i++) begin
         if (m_mm[n][i]) begin
            if (cnt == 0) first = i;
            if (cnt < sat[n]) cnt++;
         end
      end
   endfunction

   always @(posedge clk) begin
      edge_n++;
      if (reset) active = 1'b0;
      else if (start && (!active || (edge_n - s_edge) >= 12)) begin
         active = 1'b1;
         s_edge = edge_n;
         build_model();
      end
   end

   // ---------------- scoreboard ----------------
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d] at edge %0d: got %0h expected %0h", nm, idx, edge_n, act, exp);
   endtask

   always @(negedge clk) begin : compare
      int d, cnt, first;
      bit [1:0] jk_e;
      bit mm_e, done_e;
      if (chk_en) begin
         for (int n = 0; n < NI; n++) begin
            d = active ? (edge_n - s_edge) : -1;
            jk_e = 2'b00;
            mm_e = 1'b0;
            cnt = 0;
            first = 0;
            if (active) model_err(n, d - 3, cnt, first);
            if (d >= 1 && d <= 8) jk_e = m_jk[n][d-1];
            if (d >= 3 && d <= 10) mm_e = m_mm[n][d-3];
            done_e = (d == 10);
            chk("ff_reset", n, ff_reset_w[n], (d == 0));
            chk("busy", n, busy_w[n], (d >= 0 && d <= 9));
            chk("j", n, j_w[n], jk_e[1]);
            chk("k", n, k_w[n], jk_e[0]);
            chk("mismatch", n, mismatch_w[n], mm_e);
            chk("done", n, done_w[n], done_e);
            chk("pass", n, pass_w[n], (done_e && cnt == 0));
            chk("err_cnt", n, err_a[n], cnt);
            chk("first_err_idx", n, first_a[n], first);
         end
      end
   end

   // ---------------- driver ----------------
   // ctl: 0 plain run, 1 extra start during step 3, 2 reset (with start) during step 4
   task automatic run(input logic [7:0] pat, input int fm, input int ctl);
      @(negedge clk);
      pattern    = pat;
      fault_mode = fm;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (ctl == 1) begin
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (6) @(negedge clk);
      end else if (ctl == 2) begin
         repeat (4) @(negedge clk);
         reset = 1'b1;
         start = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         start = 1'b0;
         chk("abort_busy", 0, busy_w[0], 0);
         chk("abort_jk", 0, {j_w[0], k_w[0]}, 0);
         chk("abort_err", 0, err_a[0], 0);
         chk("abort_done", 0, done_w[0], 0);
         repeat (12) @(negedge clk);
      end else begin
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic final_chk(input int n, input int e_err, input int e_first, input int e_pass);
      chk("fin_done", n, done_w[n], 1);
      chk("fin_err", n, err_a[n], e_err);
      chk("fin_first", n, first_a[n], e_first);
      chk("fin_pass", n, pass_w[n], e_pass);
   endtask

   logic [15:0] lit_p0, lit_p1;

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      pattern    = 8'h00;
      fault_mode = 0;
      lit_p0     = 16'b10_01_10_01_00_10_00_00;
      lit_p1     = 16'b11_11_11_11_00_11_00_00;
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_err", 0, err_a[0], 0);
      chk("rst_busy", 0, busy_w[0], 0);

      // Correct flip-flop, both don't-care policies
      run(8'hAC, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("model_jk_p0", i, m_jk[0][i], lit_p0[2*i +: 2]);
         chk("model_jk_p1", i, m_jk[1][i], lit_p1[2*i +: 2]);
      end
      for (int n = 0; n < NI; n++) final_chk(n, 0, 0, 1);

      // q_fb stuck at 0
      run(8'hFF, 1, 0);
      final_chk(0, 8, 0, 0);
      final_chk(1, 8, 0, 0);
      final_chk(2, 3, 0, 0);

      // Flip-flop ignoring K
      run(8'h55, 2, 0);
      final_chk(0, 4, 1, 0);
      final_chk(1, 4, 1, 0);
      final_chk(2, 3, 1, 0);

      // Start during RUN is ignored
      run(8'hAC, 0, 1);
      for (int n = 0; n < NI; n++) final_chk(n, 0, 0, 1);

      // Reset mid-run, then a fresh run
      run(8'hAC, 0, 2);
      run(8'hAC, 0, 0);
      for (int n = 0; n < NI; n++) final_chk(n, 0, 0, 1);

      // Start held high: re-accepted in the cycle after DONE
      @(negedge clk);
      pattern    = 8'h3C;
      fault_mode = 0;
      start      = 1'b1;
      repeat (13) @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
